// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller: data widths,
// address/word types and the fetch state encoding.
package fetch_controller_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INSN_BYTES = 4;

  typedef logic [XLEN-1:0] word;
  typedef logic [XLEN-1:0] word_address;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  // Instructions are 4-byte aligned; any low address bit set is a fault.
  function automatic logic is_aligned(input word_address addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch controller bus: redirect/stall control, instruction memory port and
// the decoded-side fetch outputs.
interface fetch_if;
  import fetch_controller_pkg::*;

  logic                stall;
  logic                redirect_valid;
  word_address         redirect_target;
  logic                mem_read;
  word_address         mem_addr;
  word                 mem_instruction;
  logic                fetch_valid;
  word_address         fetch_pc;
  word                 fetch_instruction;
  logic                fetch_fault;
  logic [XLEN-1:0]     fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_target, mem_instruction,
    output mem_read, mem_addr, fetch_valid, fetch_pc, fetch_instruction,
           fetch_fault, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_target, mem_instruction,
    input  mem_read, mem_addr, fetch_valid, fetch_pc, fetch_instruction,
           fetch_fault, fetch_count
  );

endinterface

// File: rtl/fetch_controller.sv
// Sequential instruction fetch from a one-cycle synchronous memory, with
// stall hold, redirect and a sticky misaligned-redirect fault.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter word_address RESET_PC = 32'h0000_0000
) (
  input  logic     clock,
  input  logic     reset,
  fetch_if.master  bus
);

  if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
    $error("fetch_controller: RESET_PC must be 4-byte aligned");
  end

  fetch_state_e    r_state, w_state_n;
  word_address     r_pc, w_pc_n;
  word_address     r_fetch_pc, w_fetch_pc_n;
  logic            r_fetch_valid, w_fetch_valid_n;
  logic            r_fetch_fault, w_fetch_fault_n;
  logic [XLEN-1:0] r_fetch_count, w_fetch_count_n;
  logic            w_read;

  // Next-state: redirect beats stall; a held instruction blocks new reads.
  always_comb begin
    w_state_n       = r_state;
    w_pc_n          = r_pc;
    w_fetch_pc_n    = r_fetch_pc;
    w_fetch_valid_n = r_fetch_valid;
    w_fetch_fault_n = r_fetch_fault;
    w_fetch_count_n = r_fetch_count;
    w_read          = 1'b0;

    if (r_fetch_valid && !bus.stall) begin
      w_fetch_count_n = r_fetch_count + XLEN'(1);
    end

    case (r_state)
      BOOT: begin
        w_state_n       = RUN;
        w_fetch_valid_n = 1'b0;
        if (bus.redirect_valid) begin
          if (is_aligned(bus.redirect_target)) begin
            w_pc_n = bus.redirect_target;
          end else begin
            w_state_n       = FAULT;
            w_fetch_fault_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.redirect_valid) begin
          w_fetch_valid_n = 1'b0;
          if (is_aligned(bus.redirect_target)) begin
            w_pc_n = bus.redirect_target;
          end else begin
            w_state_n       = FAULT;
            w_fetch_fault_n = 1'b1;
          end
        end else if (!(bus.stall && r_fetch_valid)) begin
          w_read          = 1'b1;
          w_pc_n          = r_pc + word_address'(INSN_BYTES);
          w_fetch_pc_n    = r_pc;
          w_fetch_valid_n = 1'b1;
        end
      end
      FAULT: begin
        w_fetch_valid_n = 1'b0;
      end
      default: begin
        w_state_n       = BOOT;
        w_fetch_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_fetch_pc    <= RESET_PC;
      r_fetch_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_n;
      r_pc          <= w_pc_n;
      r_fetch_pc    <= w_fetch_pc_n;
      r_fetch_valid <= w_fetch_valid_n;
      r_fetch_fault <= w_fetch_fault_n;
      r_fetch_count <= w_fetch_count_n;
    end
  end

  // Memory address is the live pc; the returned word is passed straight on.
  assign bus.mem_read          = w_read;
  assign bus.mem_addr          = r_pc;
  assign bus.fetch_instruction = bus.mem_instruction;
  assign bus.fetch_valid       = r_fetch_valid;
  assign bus.fetch_pc          = r_fetch_pc;
  assign bus.fetch_fault       = r_fetch_fault;
  assign bus.fetch_count       = r_fetch_count;

endmodule
